// File: rtl/lpif_tx_quarter_packer.sv
// lpif_tx_quarter_packer
// Collects four full-rate LPIF beats and packs them into one quarter-rate word
// for the TX FIFO. The slot layout matches the RX-side quarter-rate unpacker
// bit for bit. Slot i occupies [i*SLOT_W +: SLOT_W]. Within a slot the fields
// run, from the LSB: state, protid, data, dvalid, crc, crc_valid, valid.
module lpif_tx_quarter_packer #(
    parameter int SLOTS  = 4,
    parameter int DATA_W = 256,
    parameter int CRC_W  = 16,
    parameter int SLOT_W = 4 + 2 + DATA_W + 1 + CRC_W + 1 + 1
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr_n,
    input  logic [3:0]                in_state,
    input  logic [1:0]                in_protid,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_dvalid,
    input  logic [CRC_W-1:0]          in_crc,
    input  logic                      in_crc_valid,
    input  logic                      in_valid,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic                      in_flush,
    output logic [SLOTS*SLOT_W-1:0]   txfifo_upstream_data,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [1:0]                slot_cnt,
    output logic [15:0]               word_cnt
);

    localparam int WORD_W = SLOTS * SLOT_W;
    localparam int ASM_W  = (SLOTS - 1) * SLOT_W;

    logic [ASM_W-1:0]  asm_r;         // slots 0..2 awaiting completion
    logic [WORD_W-1:0] data_r;
    logic              out_vld_r;
    logic [1:0]        slot_cnt_r;
    logic [15:0]       word_cnt_r;
    logic              flush_pend_r;  // flush requested, output register still busy
    logic              rdy_en_r;      // low until the first clock after reset release

    logic [SLOT_W-1:0] beat_s;
    logic [WORD_W-1:0] full_s;        // assembly buffer with this cycle's beat merged in
    logic              in_rdy_s;
    logic              acc_s;
    logic              can_load_s;
    logic              has_data_s;
    logic              complete_s;
    logic              load_s;

    assign beat_s = {in_valid, in_crc_valid, in_crc, in_dvalid, in_data, in_protid, in_state};

    // Handshake and word-completion decisions for the current cycle.
    always_comb begin
        in_rdy_s   = rdy_en_r & ~flush_pend_r &
                     ((slot_cnt_r != 2'd3) | ~out_vld_r | out_rdy);
        acc_s      = in_vld & in_rdy_s;
        can_load_s = ~out_vld_r | out_rdy;
        has_data_s = (slot_cnt_r != 2'd0) | acc_s;
        complete_s = (acc_s & (slot_cnt_r == 2'd3)) |
                     ((in_flush | flush_pend_r) & has_data_s);
        load_s     = complete_s & can_load_s;
    end

    // Merge an accepted beat into its slot; unfilled slots stay zero because
    // the assembly buffer is cleared every time a word leaves it.
    always_comb begin
        full_s = {{SLOT_W{1'b0}}, asm_r};
        if (acc_s) begin
            case (slot_cnt_r)
                2'd0:    full_s[0*SLOT_W +: SLOT_W] = beat_s;
                2'd1:    full_s[1*SLOT_W +: SLOT_W] = beat_s;
                2'd2:    full_s[2*SLOT_W +: SLOT_W] = beat_s;
                2'd3:    full_s[3*SLOT_W +: SLOT_W] = beat_s;
                default: full_s = {{SLOT_W{1'b0}}, asm_r};
            endcase
        end else begin
            full_s = {{SLOT_W{1'b0}}, asm_r};
        end
    end

    // Assembly buffer, output register, counters and pending-flush state.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            asm_r        <= {ASM_W{1'b0}};
            data_r       <= {WORD_W{1'b0}};
            out_vld_r    <= 1'b0;
            slot_cnt_r   <= 2'd0;
            word_cnt_r   <= 16'd0;
            flush_pend_r <= 1'b0;
            rdy_en_r     <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
            if (load_s) begin
                data_r       <= full_s;
                out_vld_r    <= 1'b1;
                asm_r        <= {ASM_W{1'b0}};
                slot_cnt_r   <= 2'd0;
                word_cnt_r   <= word_cnt_r + 16'd1;
                flush_pend_r <= 1'b0;
            end else begin
                if (out_rdy) begin
                    out_vld_r <= 1'b0;
                end
                if (acc_s) begin
                    asm_r      <= full_s[ASM_W-1:0];
                    slot_cnt_r <= slot_cnt_r + 2'd1;
                end
                if (complete_s) begin
                    flush_pend_r <= 1'b1;
                end
            end
        end
    end

    assign in_rdy               = in_rdy_s;
    assign txfifo_upstream_data = data_r;
    assign out_vld              = out_vld_r;
    assign slot_cnt             = slot_cnt_r;
    assign word_cnt             = word_cnt_r;

endmodule

// File: tb/tb_lpif_tx_quarter_packer.sv
// Bench for lpif_tx_quarter_packer: table of beat/flush vectors plus
// hand-written sequences for backpressure, pending flush, reset and wrap.
module tb_lpif_tx_quarter_packer;

    localparam int SW = 281;
    localparam int WW = 1124;

    logic            clk_wr = 1'b0;
    logic            rst_wr_n;
    logic [3:0]      in_state;
    logic [1:0]      in_protid;
    logic [255:0]    in_data;
    logic            in_dvalid;
    logic [15:0]     in_crc;
    logic            in_crc_valid;
    logic            in_valid;
    logic            in_vld;
    logic            in_rdy;
    logic            in_flush;
    logic [WW-1:0]   txfifo_upstream_data;
    logic            out_vld;
    logic            out_rdy;
    logic [1:0]      slot_cnt;
    logic [15:0]     word_cnt;

    always #5 clk_wr = ~clk_wr;

    lpif_tx_quarter_packer dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .in_state(in_state), .in_protid(in_protid), .in_data(in_data),
        .in_dvalid(in_dvalid), .in_crc(in_crc), .in_crc_valid(in_crc_valid),
        .in_valid(in_valid), .in_vld(in_vld), .in_rdy(in_rdy), .in_flush(in_flush),
        .txfifo_upstream_data(txfifo_upstream_data), .out_vld(out_vld), .out_rdy(out_rdy),
        .slot_cnt(slot_cnt), .word_cnt(word_cnt)
    );

    typedef struct {
        logic [3:0]   st;
        logic [1:0]   pid;
        logic [255:0] d;
        logic         dv;
        logic [15:0]  crc;
        logic         cv;
        logic         v;
    } beat_t;

    typedef struct {
        int nbeats;
        bit flush;
        int exp_slot;
        int exp_words;
    } vec_t;

    logic [WW-1:0] exp_q[$];
    beat_t         m_asm[4];
    int            m_cnt;
    logic [15:0]   m_words;
    int            total = 0;
    int            bad = 0;
    beat_t         zb;

    function automatic beat_t rnd_beat();
        beat_t b;
        for (int i = 0; i < 8; i++) b.d[i*32 +: 32] = $urandom;
        b.st  = 4'($urandom);
        b.pid = 2'($urandom);
        b.dv  = 1'($urandom);
        b.crc = 16'($urandom);
        b.cv  = 1'($urandom);
        b.v   = 1'($urandom);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int s = 0; s < 4; s++) begin
                if (act[s*SW +: SW] !== exp[s*SW +: SW]) begin
                    $display("FAIL %s: slot %0d got %h expected %h", name, s,
                             act[s*SW +: SW], exp[s*SW +: SW]);
                    break;
                end
            end
        end
    endtask

    // Build the expected word from the bench's own slot copies, by field offset.
    task automatic push_word();
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < m_cnt; i++) begin
            w[i*SW + 0   +: 4]   = m_asm[i].st;
            w[i*SW + 4   +: 2]   = m_asm[i].pid;
            w[i*SW + 6   +: 256] = m_asm[i].d;
            w[i*SW + 262]        = m_asm[i].dv;
            w[i*SW + 263 +: 16]  = m_asm[i].crc;
            w[i*SW + 279]        = m_asm[i].cv;
            w[i*SW + 280]        = m_asm[i].v;
        end
        exp_q.push_back(w);
        m_cnt   = 0;
        m_words = m_words + 16'd1;
    endtask

    // One clock: drive inputs, check output handshake, update the model.
    task automatic cyc(input logic vld, input beat_t b, input logic fl,
                       input logic ordy, output logic acc);
        in_vld = vld; in_state = b.st; in_protid = b.pid; in_data = b.d;
        in_dvalid = b.dv; in_crc = b.crc; in_crc_valid = b.cv; in_valid = b.v;
        in_flush = fl; out_rdy = ordy;
        #1;
        if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected: got word with none expected");
            end else begin
                chk_w("sb_word", txfifo_upstream_data, exp_q.pop_front());
            end
        end
        acc = in_vld && in_rdy;
        if (acc) begin
            m_asm[m_cnt] = b;
            m_cnt++;
            if (m_cnt == 4 || fl) push_word();
        end else if (fl && m_cnt > 0) begin
            push_word();
        end
        @(negedge clk_wr);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, zb, 1'b0, 1'b1, a);
    endtask

    // Offer one beat until accepted, bounded.
    task automatic drive_beat(input beat_t b, input logic fl, input logic ordy);
        logic a;
        int   c;
        a = 1'b0;
        c = 0;
        while (!a && c < 20) begin
            cyc(1'b1, b, fl, ordy, a);
            c++;
        end
        if (!a) begin
            total++; bad++;
            $display("FAIL beat_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic do_reset();
        rst_wr_n = 1'b0;
        in_vld = 1'b0; in_flush = 1'b0; out_rdy = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        m_words = 16'd0;
        @(negedge clk_wr);
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
        #1;
        chk("rdy_at_release", 32'(in_rdy), 32'd0);
        @(negedge clk_wr);
        #1;
        chk("rdy_after_release", 32'(in_rdy), 32'd1);
    endtask

    vec_t  vecs[10];
    beat_t bp[8];
    beat_t b;
    logic  a;
    int    k;
    logic [15:0] w0;

    initial begin
        zb = '{st: 4'd0, pid: 2'd0, d: 256'd0, dv: 1'b0, crc: 16'd0, cv: 1'b0, v: 1'b0};
        vecs[0] = '{nbeats: 4,  flush: 1'b0, exp_slot: 0, exp_words: 1};
        vecs[1] = '{nbeats: 16, flush: 1'b0, exp_slot: 0, exp_words: 4};
        vecs[2] = '{nbeats: 2,  flush: 1'b1, exp_slot: 0, exp_words: 1};
        vecs[3] = '{nbeats: 3,  flush: 1'b0, exp_slot: 3, exp_words: 0};
        vecs[4] = '{nbeats: 1,  flush: 1'b0, exp_slot: 0, exp_words: 1};
        vecs[5] = '{nbeats: 5,  flush: 1'b1, exp_slot: 0, exp_words: 2};
        vecs[6] = '{nbeats: 4,  flush: 1'b1, exp_slot: 0, exp_words: 1};
        vecs[7] = '{nbeats: 0,  flush: 1'b1, exp_slot: 0, exp_words: 0};
        vecs[8] = '{nbeats: 7,  flush: 1'b0, exp_slot: 3, exp_words: 1};
        vecs[9] = '{nbeats: 0,  flush: 1'b1, exp_slot: 0, exp_words: 1};

        rst_wr_n = 1'b0;
        in_vld = 1'b0; in_flush = 1'b0; out_rdy = 1'b0;
        in_state = '0; in_protid = '0; in_data = '0; in_dvalid = 1'b0;
        in_crc = '0; in_crc_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk_wr);
        #1;
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_slot_cnt", 32'(slot_cnt), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk_w("rst_data", txfifo_upstream_data, {WW{1'b0}});
        do_reset();

        // Basic word: data=i+1, state=i, valid=1.
        for (int i = 0; i < 4; i++) begin
            b = zb;
            b.d = 256'(i + 1);
            b.st = 4'(i);
            b.v = 1'b1;
            drive_beat(b, 1'b0, 1'b1);
        end
        #1;
        chk("basic_out_vld", 32'(out_vld), 32'd1);
        chk("basic_slot0_data", txfifo_upstream_data[6 +: 32], 32'd1);
        chk("basic_slot3_data", txfifo_upstream_data[849 +: 32], 32'd4);
        chk("basic_slot3_state", 32'(txfifo_upstream_data[843 +: 4]), 32'd3);
        chk("basic_word_cnt", 32'(word_cnt), 32'd1);
        idle(1);
        #1;
        chk("basic_out_vld_drop", 32'(out_vld), 32'd0);

        // Table-driven vectors.
        for (int v = 0; v < 10; v++) begin
            w0 = m_words;
            for (int j = 0; j < vecs[v].nbeats; j++)
                drive_beat(rnd_beat(), vecs[v].flush && (j == vecs[v].nbeats - 1), 1'b1);
            if (vecs[v].nbeats == 0 && vecs[v].flush) cyc(1'b0, zb, 1'b1, 1'b1, a);
            idle(3);
            chk($sformatf("vec%0d_slot_cnt", v), 32'(slot_cnt), 32'(vecs[v].exp_slot));
            chk($sformatf("vec%0d_word_cnt", v), 32'(word_cnt), 32'(m_words));
            chk($sformatf("vec%0d_words", v), 32'(m_words - w0), 32'(vecs[v].exp_words));
            chk($sformatf("vec%0d_drained", v), 32'(exp_q.size()), 32'd0);
        end

        // Backpressure: 8 beats offered with out_rdy low.
        for (int i = 0; i < 8; i++) bp[i] = rnd_beat();
        k = 0;
        for (int c = 0; c < 12; c++) begin
            cyc(k < 8, (k < 8) ? bp[k] : zb, 1'b0, 1'b0, a);
            if (a) k++;
        end
        #1;
        chk("bp_accepted", 32'(k), 32'd7);
        chk("bp_in_rdy", 32'(in_rdy), 32'd0);
        chk("bp_slot_cnt", 32'(slot_cnt), 32'd3);
        chk("bp_out_vld", 32'(out_vld), 32'd1);
        chk_w("bp_hold", txfifo_upstream_data, exp_q[0]);
        for (int c = 0; c < 20 && k < 8; c++) begin
            cyc(1'b1, bp[k], 1'b0, 1'b1, a);
            if (a) k++;
        end
        idle(3);
        chk("bp_all_accepted", 32'(k), 32'd8);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Flush while the output register is busy stays pending.
        for (int i = 0; i < 6; i++) drive_beat(rnd_beat(), 1'b0, 1'b0);
        cyc(1'b0, zb, 1'b1, 1'b0, a);
        cyc(1'b1, rnd_beat(), 1'b0, 1'b0, a);
        chk("pend_block0", 32'(a), 32'd0);
        cyc(1'b1, rnd_beat(), 1'b0, 1'b0, a);
        chk("pend_block1", 32'(a), 32'd0);
        idle(4);
        chk("pend_slot_cnt", 32'(slot_cnt), 32'd0);
        chk("pend_word_cnt", 32'(word_cnt), 32'(m_words));
        chk("pend_drained", 32'(exp_q.size()), 32'd0);

        // Two beats then a standalone flush: upper slots zero.
        drive_beat(rnd_beat(), 1'b0, 1'b1);
        drive_beat(rnd_beat(), 1'b0, 1'b1);
        cyc(1'b0, zb, 1'b1, 1'b0, a);
        #1;
        chk("flush_out_vld", 32'(out_vld), 32'd1);
        chk_w("flush_upper_zero", {562'd0, txfifo_upstream_data[562 +: 562]}, {WW{1'b0}});
        chk("flush_slot_cnt", 32'(slot_cnt), 32'd0);
        idle(3);

        // Reset in the middle of a word.
        for (int i = 0; i < 3; i++) drive_beat(rnd_beat(), 1'b0, 1'b1);
        rst_wr_n = 1'b0;
        #1;
        chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_slot_cnt", 32'(slot_cnt), 32'd0);
        chk("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        do_reset();
        for (int i = 0; i < 4; i++) drive_beat(rnd_beat(), 1'b0, 1'b1);
        idle(3);
        chk("post_rst_word_cnt", 32'(word_cnt), 32'd1);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        // Word counter wrap.
        force dut.word_cnt_r = 16'hFFFE;
        #1;
        release dut.word_cnt_r;
        m_words = 16'hFFFE;
        @(negedge clk_wr);
        drive_beat(rnd_beat(), 1'b1, 1'b1);
        idle(2);
        chk("wrap_ffff", 32'(word_cnt), 32'h0000FFFF);
        drive_beat(rnd_beat(), 1'b1, 1'b1);
        idle(2);
        chk("wrap_zero", 32'(word_cnt), 32'(m_words));
        chk("wrap_zero_abs", 32'(word_cnt), 32'd0);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
